turn_timer: RTL and testbench

//   Per-turn countdown timer for the game. Produces the seconds[3:0] value

---
 rtl/game_pkg.sv | 9 +
 rtl/tick_gen.sv | 31 +++
 rtl/turn_timer.sv | 84 ++++++++
 tb/tb_turn_timer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game types: turn-timer FSM state encoding and the default turn length.
// Pure declarations, no logic; imported by the timer and any FSM that decodes its state.
package game_pkg;

  typedef enum logic [1:0] {T_IDLE, T_RUN, T_EXPIRED} timer_state_t;

  localparam int TURN_SECONDS_DEFAULT = 10;

endpackage

// File: rtl/tick_gen.sv
// 1 Hz prescaler: counts 0..CLK_FREQ_HZ-1 while en, tick is high combinationally at the terminal count.
// Latency: first tick CLK_FREQ_HZ cycles after clr drops with en high; no backpressure, clr wins over en.
module tick_gen #(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  // A 1 Hz clock would give a zero-width counter; keep at least one bit.
  localparam int          W    = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [W-1:0] TERM = W'(CLK_FREQ_HZ - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == TERM) ? '0 : r_cnt + W'(1);
    end
  end

  assign tick = en && (r_cnt == TERM);

endmodule

// File: rtl/turn_timer.sv
// Per-turn countdown: loads TURN_SECONDS on start, decrements at 1 Hz, pulses timeout on reaching 0.
// Outputs registered, valid the cycle after the causing edge; no backpressure, priority start > stop > tick.
module turn_timer
  import game_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int TURN_SECONDS = TURN_SECONDS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] seconds,
  output logic       running,
  output logic       timeout
);

  localparam logic [3:0] RELOAD = 4'(TURN_SECONDS);

  timer_state_t r_state;
  timer_state_t w_state_nxt;
  logic [3:0]   r_seconds;
  logic [3:0]   w_seconds_nxt;
  logic         r_running;
  logic         r_timeout;
  logic         w_timeout_nxt;
  logic         w_tick;
  logic         w_pre_en;
  logic         w_pre_clr;

  // Any start or stop realigns the second boundary to the command.
  assign w_pre_en  = (r_state == T_RUN);
  assign w_pre_clr = start || stop || (r_state != T_RUN);

  tick_gen #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (w_pre_en),
    .clr  (w_pre_clr),
    .tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= T_IDLE;
      r_seconds <= RELOAD;
      r_running <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_seconds <= w_seconds_nxt;
      r_running <= (w_state_nxt == T_RUN);
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_seconds_nxt = r_seconds;
    w_timeout_nxt = 1'b0;
    if (start) begin
      w_state_nxt   = T_RUN;
      w_seconds_nxt = RELOAD;
    end else if (stop) begin
      w_state_nxt   = T_IDLE;
      w_seconds_nxt = RELOAD;
    end else if ((r_state == T_RUN) && w_tick) begin
      if (r_seconds > 4'd1) begin
        w_seconds_nxt = r_seconds - 4'd1;
      end else begin
        w_state_nxt   = T_EXPIRED;
        w_seconds_nxt = 4'd0;
        w_timeout_nxt = 1'b1;
      end
    end
  end

  assign seconds = r_seconds;
  assign running = r_running;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_turn_timer.sv
// Directed bench for turn_timer at CLK_FREQ_HZ=4, TURN_SECONDS=10.
// Expected {seconds, running, timeout} values are hand-derived per scenario.
module tb_turn_timer;

  localparam int CLK_HZ = 4;
  localparam int TS     = 10;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic [3:0] seconds;
  logic       running;
  logic       timeout;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  turn_timer #(
    .CLK_FREQ_HZ  (CLK_HZ),
    .TURN_SECONDS (TS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .seconds (seconds),
    .running (running),
    .timeout (timeout)
  );

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic p);
    start = s;
    stop  = p;
    step();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    #3 rst = 1'b1;
    #1;
    exp = {4'd10, 1'b0, 1'b0};
    n_total++;
    if ({seconds, running, timeout} !== exp)
      $display("FAIL reset_async: got sec=%0d run=%b to=%b, want sec=%0d run=%b to=%b",
               seconds, running, timeout, exp[5:2], exp[1], exp[0]);
    else n_pass++;
    step();
    step();
    rst = 1'b0;
    repeat (3) step();
    n_total++;
    if ({seconds, running, timeout} !== exp)
      $display("FAIL reset_idle: got sec=%0d run=%b to=%b, want sec=%0d run=%b to=%b",
               seconds, running, timeout, exp[5:2], exp[1], exp[0]);
    else n_pass++;
  endtask

  task automatic test_full_turn();
    logic [5:0] exp;
    pulse(1'b1, 1'b0);
    exp = {4'd10, 1'b1, 1'b0};
    n_total++;
    if ({seconds, running, timeout} !== exp)
      $display("FAIL full_start: got sec=%0d run=%b to=%b, want sec=%0d run=%b to=%b",
               seconds, running, timeout, exp[5:2], exp[1], exp[0]);
    else n_pass++;
    for (int n = 1; n <= TS * CLK_HZ; n++) begin
      step();
      exp = {4'(TS - n / CLK_HZ), (n < TS * CLK_HZ), (n == TS * CLK_HZ)};
      n_total++;
      if ({seconds, running, timeout} !== exp)
        $display("FAIL full_count cyc=%0d: got sec=%0d run=%b to=%b, want sec=%0d run=%b to=%b",
                 n, seconds, running, timeout, exp[5:2], exp[1], exp[0]);
      else n_pass++;
    end
    exp = {4'd0, 1'b0, 1'b0};
    for (int n = 1; n <= 20; n++) begin
      step();
      n_total++;
      if ({seconds, running, timeout} !== exp)
        $display("FAIL expired_hold cyc=%0d: got sec=%0d run=%b to=%b, want sec=%0d run=%b to=%b",
                 n, seconds, running, timeout, exp[5:2], exp[1], exp[0]);
      else n_pass++;
    end
  endtask

  task automatic test_restart();
    logic [5:0] exp;
    pulse(1'b1, 1'b0);
    repeat (14) step();
    exp = {4'd7, 1'b1, 1'b0};
    n_total++;
    if ({seconds, running, timeout} !== exp)
      $display("FAIL restart_pre: got sec=%0d run=%b to=%b, want sec=%0d run=%b to=%b",
               seconds, running, timeout, exp[5:2], exp[1], exp[0]);
    else n_pass++;
    pulse(1'b1, 1'b0);
    for (int n = 0; n <= 4; n++) begin
      if (n > 0) step();
      exp = {(n < 4) ? 4'd10 : 4'd9, 1'b1, 1'b0};
      n_total++;
      if ({seconds, running, timeout} !== exp)
        $display("FAIL restart_realign cyc=%0d: got sec=%0d run=%b to=%b, want sec=%0d run=%b to=%b",
                 n, seconds, running, timeout, exp[5:2], exp[1], exp[0]);
      else n_pass++;
    end
    // Prescaler is at its terminal count during the cycle where start is applied.
    repeat (3) step();
    pulse(1'b1, 1'b0);
    for (int n = 0; n <= 4; n++) begin
      if (n > 0) step();
      exp = {(n < 4) ? 4'd10 : 4'd9, 1'b1, 1'b0};
      n_total++;
      if ({seconds, running, timeout} !== exp)
        $display("FAIL restart_on_tick cyc=%0d: got sec=%0d run=%b to=%b, want sec=%0d run=%b to=%b",
                 n, seconds, running, timeout, exp[5:2], exp[1], exp[0]);
      else n_pass++;
    end
    pulse(1'b0, 1'b1);
  endtask

  task automatic test_stop();
    logic [5:0] exp;
    pulse(1'b1, 1'b0);
    repeat (28) step();
    exp = {4'd3, 1'b1, 1'b0};
    n_total++;
    if ({seconds, running, timeout} !== exp)
      $display("FAIL stop_pre: got sec=%0d run=%b to=%b, want sec=%0d run=%b to=%b",
               seconds, running, timeout, exp[5:2], exp[1], exp[0]);
    else n_pass++;
    pulse(1'b0, 1'b1);
    exp = {4'd10, 1'b0, 1'b0};
    for (int n = 0; n <= 40; n++) begin
      if (n > 0) step();
      n_total++;
      if ({seconds, running, timeout} !== exp)
        $display("FAIL stop_idle cyc=%0d: got sec=%0d run=%b to=%b, want sec=%0d run=%b to=%b",
                 n, seconds, running, timeout, exp[5:2], exp[1], exp[0]);
      else n_pass++;
    end
  endtask

  task automatic test_collisions();
    logic [5:0] exp;
    pulse(1'b1, 1'b0);
    repeat (TS * CLK_HZ - 1) step();
    exp = {4'd1, 1'b1, 1'b0};
    n_total++;
    if ({seconds, running, timeout} !== exp)
      $display("FAIL coll_pre_final: got sec=%0d run=%b to=%b, want sec=%0d run=%b to=%b",
               seconds, running, timeout, exp[5:2], exp[1], exp[0]);
    else n_pass++;
    pulse(1'b0, 1'b1);
    exp = {4'd10, 1'b0, 1'b0};
    for (int n = 0; n <= 8; n++) begin
      if (n > 0) step();
      n_total++;
      if ({seconds, running, timeout} !== exp)
        $display("FAIL coll_stop_final cyc=%0d: got sec=%0d run=%b to=%b, want sec=%0d run=%b to=%b",
                 n, seconds, running, timeout, exp[5:2], exp[1], exp[0]);
      else n_pass++;
    end
    pulse(1'b1, 1'b0);
    repeat (TS * CLK_HZ) step();
    exp = {4'd0, 1'b0, 1'b1};
    n_total++;
    if ({seconds, running, timeout} !== exp)
      $display("FAIL coll_expire: got sec=%0d run=%b to=%b, want sec=%0d run=%b to=%b",
               seconds, running, timeout, exp[5:2], exp[1], exp[0]);
    else n_pass++;
    step();
    step();
    pulse(1'b1, 1'b1);
    exp = {4'd10, 1'b1, 1'b0};
    n_total++;
    if ({seconds, running, timeout} !== exp)
      $display("FAIL coll_start_stop: got sec=%0d run=%b to=%b, want sec=%0d run=%b to=%b",
               seconds, running, timeout, exp[5:2], exp[1], exp[0]);
    else n_pass++;
    repeat (4) step();
    exp = {4'd9, 1'b1, 1'b0};
    n_total++;
    if ({seconds, running, timeout} !== exp)
      $display("FAIL coll_start_stop_dec: got sec=%0d run=%b to=%b, want sec=%0d run=%b to=%b",
               seconds, running, timeout, exp[5:2], exp[1], exp[0]);
    else n_pass++;
    pulse(1'b0, 1'b1);
  endtask

  task automatic test_midcount_reset();
    logic [5:0] exp;
    pulse(1'b1, 1'b0);
    repeat (20) step();
    exp = {4'd5, 1'b1, 1'b0};
    n_total++;
    if ({seconds, running, timeout} !== exp)
      $display("FAIL midrst_pre: got sec=%0d run=%b to=%b, want sec=%0d run=%b to=%b",
               seconds, running, timeout, exp[5:2], exp[1], exp[0]);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    exp = {4'd10, 1'b0, 1'b0};
    n_total++;
    if ({seconds, running, timeout} !== exp)
      $display("FAIL midrst_async: got sec=%0d run=%b to=%b, want sec=%0d run=%b to=%b",
               seconds, running, timeout, exp[5:2], exp[1], exp[0]);
    else n_pass++;
    step();
    step();
    rst = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      step();
      n_total++;
      if ({seconds, running, timeout} !== exp)
        $display("FAIL midrst_no_resume cyc=%0d: got sec=%0d run=%b to=%b, want sec=%0d run=%b to=%b",
                 n, seconds, running, timeout, exp[5:2], exp[1], exp[0]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_full_turn();
    test_restart();
    test_stop();
    test_collisions();
    test_midcount_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
